// File: rtl/keymill_pkg.sv
// Shared definitions for the keymill FIFO arbiter: FSM encoding, size limits
// and a small modular-wrap helper used by the round-robin picker.
package keymill_pkg;

  localparam int MAX_N_REQ   = 4;
  localparam int BURST_CNT_W = 4;
  localparam int WORD_W      = 32;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Wraps v into [0, n) assuming v < 2n, which holds for owner + offset
  // where owner < n and offset <= n.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/keymill_rr_pick.sv
// Rotating-priority selector: scans requesters starting just after the last
// owner and returns the first one found as a one-hot grant plus its index.
// With no request the index stays at the last owner and the grant is zero.
module rr_pick
  import keymill_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [1:0]       i_last,
  output logic [N_REQ-1:0] o_grant,
  output logic [1:0]       o_idx
);

  logic w_found;
  int   w_cand;

  // Walk owner+1, owner+2, ... owner+N_REQ (mod N_REQ); the last candidate
  // is the previous owner itself, so a lone requester can win again.
  always_comb begin
    o_grant = '0;
    o_idx   = i_last;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = rr_wrap(int'(i_last) + k, N_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand[1:0];
      end
    end
  end

endmodule

// File: rtl/keymill_fifo_arb.sv
// Round-robin arbiter feeding a single 32-bit word FIFO from up to four
// producers. A grant lasts until the owner drops its request or MAX_BURST
// words have been accepted; one IDLE cycle always separates grants.
module keymill_fifo_arb
  import keymill_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [WORD_W*N_REQ-1:0] data,
  output logic [N_REQ-1:0]        ack,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [WORD_W-1:0]       fifo_din,
  output logic                    busy,
  output logic [1:0]              owner
);

  localparam logic [BURST_CNT_W-1:0] LAST_CNT  = BURST_CNT_W'(MAX_BURST - 1);
  localparam logic [1:0]             RST_OWNER = 2'(N_REQ - 1);

  logic [0:0]             r_state;
  logic [1:0]             r_owner;
  logic [BURST_CNT_W-1:0] r_burst_cnt;

  logic [MAX_N_REQ-1:0] w_req_ext;
  logic [WORD_W-1:0]    w_words [MAX_N_REQ];
  logic [MAX_N_REQ-1:0] w_ack_ext;
  logic [N_REQ-1:0]     w_pick_grant;
  logic [1:0]           w_pick_idx;
  logic                 w_any_req;
  logic                 w_owner_req;
  logic                 w_in_grant;
  logic                 w_wr_en;
  logic                 w_last_word;

  // Widen the producer bus to the package maximum so owner can index it
  // directly regardless of N_REQ; unused slots read as idle/zero.
  for (genvar gi = 0; gi < MAX_N_REQ; gi++) begin : g_ext
    if (gi < N_REQ) begin : g_used
      assign w_req_ext[gi] = req[gi];
      assign w_words[gi]   = data[WORD_W*gi +: WORD_W];
    end else begin : g_pad
      assign w_req_ext[gi] = 1'b0;
      assign w_words[gi]   = '0;
    end
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .i_req   (req),
    .i_last  (r_owner),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx)
  );

  assign w_any_req   = |w_pick_grant;
  assign w_owner_req = w_req_ext[r_owner];
  // Outputs are forced quiet during reset even if the state register still
  // holds GRANT from before reset was sampled.
  assign w_in_grant  = (r_state == ST_GRANT) && !rst;
  assign w_wr_en     = w_in_grant && w_owner_req && !fifo_full;
  assign w_last_word = (r_burst_cnt == LAST_CNT);

  // Acknowledge only the owner, and only for a word actually written.
  always_comb begin
    w_ack_ext          = '0;
    w_ack_ext[r_owner] = w_wr_en;
  end

  assign ack        = w_ack_ext[N_REQ-1:0];
  assign fifo_wr_en = w_wr_en;
  assign fifo_din   = w_words[r_owner];
  assign busy       = w_in_grant;
  assign owner      = r_owner;

  // FSM: IDLE arbitrates for one cycle, GRANT streams the owner's words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) r_state <= ST_GRANT;
        end
        ST_GRANT: begin
          if (!w_owner_req) begin
            r_state <= ST_IDLE;
          end else if (w_wr_en && w_last_word) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Owner is loaded only when a grant starts, so it also records the last
  // winner and seeds the next round-robin search.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= RST_OWNER;
    end else if ((r_state == ST_IDLE) && w_any_req) begin
      r_owner <= w_pick_idx;
    end
  end

  // Burst counter clears at grant start and counts accepted words only, so
  // it freezes while the FIFO is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_any_req) r_burst_cnt <= '0;
    end else if (w_wr_en) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_keymill_fifo_arb.sv
// Directed bench for keymill_fifo_arb. Stimulus pushes the hand-derived word
// sequence each scenario must produce; an independent negedge monitor pops
// and compares whenever the FIFO write strobe is seen.
module tb_keymill_fifo_arb;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] data = '0;
  logic [N-1:0]    ack;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_en;
  logic [31:0]     fifo_din;
  logic            busy;
  logic [1:0]      owner;

  int          total = 0;
  int          bad   = 0;
  logic [33:0] sb_q[$];
  int          seq[N];
  logic [N-1:0] ack_last = '0;

  always #5 clk = ~clk;

  keymill_fifo_arb #(
    .N_REQ     (4),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data       (data),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .busy       (busy),
    .owner      (owner)
  );

  function automatic logic [31:0] wv(int i, int n);
    return 32'hC0DE_0000 + 32'(i * 256) + 32'(n);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(int i, int n);
    sb_q.push_back({2'(i), wv(i, n)});
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) data[32*i +: 32] = wv(i, seq[i]);
  endtask

  // Advance one clock; producers step to their next word after an ack.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (ack_last[i]) seq[i]++;
    drive_data();
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    req = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    drive_data();
    @(negedge clk);
    cyc();
    @(negedge clk);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [33:0] e;
    ack_last = ack;
    if (fifo_full) chk("wr_while_full", 64'(fifo_wr_en), 64'd0);
    chk("ack_vs_wr", 64'(ack), fifo_wr_en ? 64'(4'b0001 << owner) : 64'd0);
    if (fifo_wr_en) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_write actual=%0h required=none", {owner, fifo_din});
      end else begin
        e = sb_q.pop_front();
        chk("sb_word", 64'({owner, fifo_din}), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat12;
    logic [8:0]  pat9;
    for (int i = 0; i < N; i++) seq[i] = 0;
    drive_data();

    // Reset with no requests
    @(negedge clk);
    chk("s031_rst_wr", 64'(fifo_wr_en), 64'd0);
    chk("s031_rst_ack", 64'(ack), 64'd0);
    chk("s031_rst_busy", 64'(busy), 64'd0);
    cyc();
    @(negedge clk);
    chk("s031_rst_owner", 64'(owner), 64'd3);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("s031_idle_owner", 64'(owner), 64'd3);
    chk("s031_idle_busy", 64'(busy), 64'd0);
    chk("s031_idle_wr", 64'(fifo_wr_en), 64'd0);
    cyc();
    @(negedge clk);
    chk("s031_hold_owner", 64'(owner), 64'd3);
    chk("s031_hold_busy", 64'(busy), 64'd0);

    // req=0101: grant 0 x4, idle, grant 2 x4, idle, grant 0 again
    do_reset();
    for (int j = 0; j < 4; j++) push(0, j);
    for (int j = 0; j < 4; j++) push(2, j);
    push(0, 4);
    cyc();
    rst = 1'b0;
    req = 4'b0101;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      pat12[k] = fifo_wr_en;
      if (k == 5) chk("s032_second_owner_pending", 64'(owner), 64'd0);
      if (k == 6) chk("s032_second_owner", 64'(owner), 64'd2);
      if (k == 11) chk("s032_third_owner", 64'(owner), 64'd0);
    end
    chk("s032_wr_pattern", 64'(pat12), 64'hBDE);
    cyc();
    req = '0;
    @(negedge clk);
    chk("s032_drop_wr", 64'(fifo_wr_en), 64'd0);
    cyc();
    @(negedge clk);
    chk("s032_end_busy", 64'(busy), 64'd0);
    chk("s032_sb_drain", 64'(sb_q.size()), 64'd0);

    // Requester 1 alone: two words then drops req
    do_reset();
    push(1, 0);
    push(1, 1);
    cyc();
    rst = 1'b0;
    req = 4'b0010;
    @(negedge clk);
    chk("s033_arb_busy", 64'(busy), 64'd0);
    cyc();
    @(negedge clk);
    chk("s033_w0_wr", 64'(fifo_wr_en), 64'd1);
    chk("s033_owner", 64'(owner), 64'd1);
    cyc();
    @(negedge clk);
    chk("s033_w1_wr", 64'(fifo_wr_en), 64'd1);
    cyc();
    req = '0;
    @(negedge clk);
    chk("s033_drop_wr", 64'(fifo_wr_en), 64'd0);
    chk("s033_drop_busy", 64'(busy), 64'd1);
    cyc();
    @(negedge clk);
    chk("s033_exit_busy", 64'(busy), 64'd0);
    chk("s033_exit_owner", 64'(owner), 64'd1);
    cyc();
    @(negedge clk);
    chk("s033_hold_owner", 64'(owner), 64'd1);
    chk("s033_sb_drain", 64'(sb_q.size()), 64'd0);

    // fifo_full for 3 cycles after the 2nd word
    do_reset();
    for (int j = 0; j < 4; j++) push(0, j);
    cyc();
    rst = 1'b0;
    req = 4'b0001;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) cyc();
      if (k == 3) fifo_full = 1'b1;
      if (k == 6) fifo_full = 1'b0;
      if (k == 8) req = '0;
      @(negedge clk);
      pat9[k] = fifo_wr_en;
      if (k >= 3 && k <= 5) begin
        chk("s034_full_busy", 64'(busy), 64'd1);
        chk("s034_full_ack", 64'(ack), 64'd0);
      end
    end
    chk("s034_wr_pattern", 64'(pat9), 64'h0C6);
    chk("s034_end_busy", 64'(busy), 64'd0);
    chk("s034_sb_drain", 64'(sb_q.size()), 64'd0);

    // Reset after the 2nd word of a burst
    do_reset();
    push(0, 0);
    push(0, 1);
    push(0, 2);
    cyc();
    rst = 1'b0;
    req = 4'b0101;
    @(negedge clk);
    cyc();
    @(negedge clk);
    cyc();
    @(negedge clk);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("s035_rst_wr", 64'(fifo_wr_en), 64'd0);
    chk("s035_rst_ack", 64'(ack), 64'd0);
    chk("s035_rst_busy", 64'(busy), 64'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("s035_idle_busy", 64'(busy), 64'd0);
    chk("s035_idle_owner", 64'(owner), 64'd3);
    cyc();
    @(negedge clk);
    chk("s035_regrant_wr", 64'(fifo_wr_en), 64'd1);
    chk("s035_regrant_owner", 64'(owner), 64'd0);
    cyc();
    req = '0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("s035_sb_drain", 64'(sb_q.size()), 64'd0);

    // All four requesting for 40 cycles
    do_reset();
    for (int g = 0; g < 8; g++)
      for (int j = 0; j < 4; j++) push(g % 4, (g / 4) * 4 + j);
    cyc();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      chk("s036_wr_slot", 64'(fifo_wr_en), 64'((k % 5) != 0));
    end
    cyc();
    req = '0;
    @(negedge clk);
    chk("s036_end_busy", 64'(busy), 64'd0);
    cyc();
    @(negedge clk);
    chk("s036_sb_drain", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keymill_fifo_arb.md
KEYMILL_FIFO_ARB -- requirements
Module: keymill_fifo_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of producer ports (2..4).
REQ-002 Parameter MAX_BURST, default 4, maximum words accepted per grant (1..8).
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  N_REQ  per-producer request; bit i high means data_i holds a valid word.
REQ-006 data  input  32*N_REQ  packed producer words; word i is bits [32i+31:32i].
REQ-007 ack  output  N_REQ  one-hot pulse; bit i high means word i was written this cycle.
REQ-008 fifo_full  input  1  full flag from the 32-bit word FIFO.
REQ-009 fifo_wr_en  output  1  write strobe to the FIFO.
REQ-010 fifo_din  output  32  word to the FIFO.
REQ-011 busy  output  1  high while in GRANT.
REQ-012 owner  output  2  index of the current or last granted producer.

Function
REQ-013 The arbiter SHALL be a two-state FSM with states IDLE and GRANT.
REQ-014 In IDLE with any req bit high, the arbiter SHALL select the first requester in round-robin order starting at (owner+1) mod N_REQ, load owner with it, clear burst_cnt and enter GRANT on the next edge.
REQ-015 In IDLE with req all zero, the arbiter SHALL remain in IDLE and hold owner.
REQ-016 In GRANT, fifo_wr_en SHALL equal req[owner] AND NOT fifo_full, combinationally.
REQ-017 fifo_din SHALL equal data word [owner] at all times; its value is only meaningful while fifo_wr_en is high.
REQ-018 ack[owner] SHALL equal fifo_wr_en, and all other ack bits SHALL be 0; in IDLE ack SHALL be all zero.
REQ-019 Each accepted word (fifo_wr_en high) SHALL increment burst_cnt, a 4-bit counter.
REQ-020 GRANT SHALL return to IDLE on the edge where req[owner] is low, or where a word is accepted with burst_cnt equal to MAX_BURST-1.
REQ-021 While fifo_full is high and req[owner] is high, GRANT SHALL be held with no write and no ack; burst_cnt SHALL be unchanged; there is no timeout.
REQ-022 A producer SHALL keep req and its data stable until it sees ack; it may present a new word in the cycle after ack.
REQ-023 At least one IDLE cycle SHALL separate consecutive grants, so the arbitration latency is exactly one cycle from IDLE.
REQ-024 Requests from non-owners during GRANT SHALL be ignored until the next IDLE cycle.
REQ-025 The arbiter SHALL never assert fifo_wr_en while fifo_full is high.

Reset
REQ-026 While rst is high at a posedge clk, the arbiter SHALL set state to IDLE, burst_cnt to 0 and owner to N_REQ-1, so that requester 0 has first priority.
REQ-027 While the arbiter is in reset, fifo_wr_en SHALL be 0, ack SHALL be 0 and busy SHALL be 0.
REQ-028 A reset asserted mid-burst SHALL abort the grant; the FIFO is not rolled back.

Structure
REQ-029 The state encoding and the constants MAX_N_REQ=4 and BURST_CNT_W=4 SHALL live in a shared package, keymill_pkg.
REQ-030 The rotating-priority select SHALL be one combinational sub-module, rr_pick, with inputs req and last-owner and outputs a one-hot grant and an index.

Verification
REQ-031 Scenario: rst high for 2 cycles, then req=0 -> fifo_wr_en=0, ack=0, busy=0, owner=3.
REQ-032 Scenario: req=4'b0101 held, fifo_full=0, MAX_BURST=4 -> grant 0 writes 4 words, then 1 idle cycle, then grant 2 writes 4 words, then grant 0 again.
REQ-033 Scenario: requester 1 alone sends 2 words and then drops req -> 2 acks, GRANT exits on the edge where req drops, and owner stays 1.
REQ-034 Scenario: fifo_full high for 3 cycles mid-burst with req[owner] high -> no write for 3 cycles, burst_cnt frozen, remaining words written after fifo_full falls.
REQ-035 Scenario: rst asserted after the 2nd word of a burst -> IDLE next cycle, owner=3, and the next grant goes to requester 0 if its req is high.
REQ-036 Scenario: req=4'b1111 for 40 cycles -> grant order 0,1,2,3,0..., each grant 4 writes, and every fifo_din matches the owner's data.
